// File: rtl/data_mem_be.sv
// Byte-addressable RV32 data memory: SB/SH/SW stores, signed/unsigned loads, self-clear after reset,
// and a req/ack debug port for the halted-core loader. Define DATA_MEM_MISALIGN_TRAP_EN to flag misaligned accesses.
module data_mem_be #(
  parameter int DEPTH      = 1024,
  parameter int DBG_ADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [2:0]            funct3,
  output logic [31:0]           rdata,
  output logic                  misaligned,
  output logic                  busy,
  input  logic                  cpu_enable,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DBG_ADDR_W-1:0] dbg_addr,
  input  logic [31:0]           dbg_wdata,
  output logic                  dbg_ack,
  output logic [DBG_ADDR_W+32:0] dbg_frame,
  output logic [31:0]           word0
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_ACK, ST_REL} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           clr_idx_q, clr_idx_d;
  logic [DBG_ADDR_W+32:0]  dbg_frame_q, dbg_frame_d;
  logic [3:0][7:0]         mem_q [DEPTH];

  logic [AW-1:0]   cpu_idx, dbg_idx, wr_idx;
  logic [31:0]     dbg_addr_ext;
  logic [3:0][7:0] rd_bytes;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [3:0]      st_be, wr_be;
  logic [31:0]     st_data, wr_data;
  logic            is_half, is_word, mis_raw, cpu_store, dbg_accept;
  logic            unused_bits;

  assign cpu_idx      = addr[AW+1:2];
  assign dbg_addr_ext = 32'(dbg_addr);
  assign dbg_idx      = dbg_addr_ext[AW-1:0];
  assign unused_bits  = ^{addr[31:AW+2], dbg_addr_ext[31:AW]};

  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = (funct3 == 3'b010);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign mis_raw    = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
  assign misaligned = (mem_read || mem_write) && mis_raw;
`else
  // Halves and words are force-aligned by dropping the low address bits.
  assign mis_raw    = 1'b0;
  assign misaligned = 1'b0;
`endif

  // Store lane steering: data is replicated so each enabled lane sees its slice.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    st_be   = 4'b0000;
    st_data = wdata;
    case (funct3)
      3'b000: begin
        st_be   = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      3'b001: begin
        st_be   = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      3'b010:  st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  assign cpu_store = mem_write && (state_q != ST_CLEAR) && !mis_raw;

  // Single write port: clear, then CPU store, then debug write (debug only accepted without a store).
  always_comb begin
    wr_be   = 4'b0000;
    wr_idx  = cpu_idx;
    wr_data = st_data;
    if (state_q == ST_CLEAR) begin
      wr_be   = 4'b1111;
      wr_idx  = clr_idx_q;
      wr_data = '0;
    end else if (cpu_store) begin
      wr_be = st_be;
    end else if (dbg_accept && dbg_we) begin
      wr_be   = 4'b1111;
      wr_idx  = dbg_idx;
      wr_data = dbg_wdata;
    end
  end

  // NOTE: the array has no reset; the CLEAR sequence zeroes it so it can map onto RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem_q[wr_idx][b] <= wr_data[8*b +: 8];
    end
  end

  assign rd_bytes = mem_q[cpu_idx];
  assign ld_byte  = rd_bytes[addr[1:0]];
  assign ld_half  = addr[1] ? rd_bytes[3:2] : rd_bytes[1:0];

  always_comb begin
    rdata = '0;
    if (mem_read && (state_q != ST_CLEAR) && !mis_raw) begin
      case (funct3)
        3'b000:  rdata = {{24{ld_byte[7]}}, ld_byte};
        3'b001:  rdata = {{16{ld_half[15]}}, ld_half};
        3'b010:  rdata = rd_bytes;
        3'b100:  rdata = {24'b0, ld_byte};
        3'b101:  rdata = {16'b0, ld_half};
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    dbg_frame_d = dbg_frame_q;
    dbg_accept  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (dbg_req && !cpu_enable && !mem_write) begin
          dbg_accept = 1'b1;
          state_d    = ST_ACK;
          if (!dbg_we) dbg_frame_d = {1'b0, dbg_addr, mem_q[dbg_idx]};
        end
      end
      ST_ACK:  state_d = ST_REL;
      // Hold here until the requester drops dbg_req so a held request is served once.
      ST_REL:  if (!dbg_req) state_d = ST_IDLE;
      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      dbg_frame_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      dbg_frame_q <= dbg_frame_d;
    end
  end

  assign busy      = (state_q == ST_CLEAR);
  assign dbg_ack   = (state_q == ST_ACK);
  assign dbg_frame = dbg_frame_q;
  assign word0     = mem_q[0];

endmodule

// File: tb/tb_data_mem_be.sv
// Directed bench for data_mem_be (DEPTH=16): clear sequencing, load/store vector table,
// debug handshake, store-over-debug priority and reset abort mid-clear.
module tb_data_mem_be;

  localparam int DEPTH      = 16;
  localparam int DBG_ADDR_W = 9;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [31:0]           addr, wdata;
  logic                  mem_write, mem_read;
  logic [2:0]            funct3;
  logic [31:0]           rdata;
  logic                  misaligned, busy;
  logic                  cpu_enable, dbg_req, dbg_we;
  logic [DBG_ADDR_W-1:0] dbg_addr;
  logic [31:0]           dbg_wdata;
  logic                  dbg_ack;
  logic [DBG_ADDR_W+32:0] dbg_frame;
  logic [31:0]           word0;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  data_mem_be #(.DEPTH(DEPTH), .DBG_ADDR_W(DBG_ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata),
    .mem_write(mem_write), .mem_read(mem_read), .funct3(funct3),
    .rdata(rdata), .misaligned(misaligned), .busy(busy),
    .cpu_enable(cpu_enable), .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
    .dbg_frame(dbg_frame), .word0(word0)
  );

  always @(negedge clk) if (dbg_ack) ack_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cpu_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp,
                          input string name);
    @(posedge clk); #1;
    mem_write = 1'b0; mem_read = 1'b1; funct3 = f3; addr = a;
    #2 check(name, rdata, exp);
    mem_read = 1'b0;
  endtask

  task automatic cpu_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    mem_write = 1'b1; mem_read = 1'b0; funct3 = f3; addr = a; wdata = d;
    @(posedge clk); #1;
    mem_write = 1'b0;
  endtask

  task automatic count_clear(input string name);
    int cnt;
    cnt = 0;
    while (busy && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(name, cnt, DEPTH);
  endtask

  // One debug transaction with dbg_req held for several cycles past the ack.
  task automatic dbg_txn(input logic we, input logic [8:0] a, input logic [31:0] wd, input string name);
    int base, lat;
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    base = ack_cnt;
    lat  = 0;
    while (!dbg_ack && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_ack_latency"}, lat, 1);
    repeat (4) @(posedge clk);
    #1 dbg_req = 1'b0;
    @(posedge clk); #1;
    check({name, "_ack_pulses"}, ack_cnt - base, 1);
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, lat;

    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h04, 32'h11223344, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h05, 32'h123456AA, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h06, 32'h9999BEEF, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h04, 32'h0, 32'hBEEFAA44, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 3'b000, 32'h05, 32'h0, 32'hFFFFFFAA, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'b100, 32'h05, 32'h0, 32'h000000AA, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h06, 32'h0, 32'hFFFFBEEF, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b101, 32'h06, 32'h0, 32'h0000BEEF, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h04, 32'h0, 32'h00000044, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h04, 32'h0, 32'hFFFFAA44, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'b011, 32'h04, 32'h0, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 3'b010, 32'h04, 32'h0, 32'h0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h04, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 3'b010, 32'h04, 32'h0, 32'hBEEFAA44, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 3'b100, 32'h07, 32'h0, 32'h000000BE, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 3'b000, 32'h07, 32'h0, 32'hFFFFFFBE, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 3'b010, 32'h44, 32'h0, 32'hBEEFAA44, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 3'b010, 32'h06, 32'h55555555, 32'h0, TRAP};
    vecs[18] = '{1'b0, 1'b1, 3'b010, 32'h04, 32'h0, TRAP ? 32'hBEEFAA44 : 32'h55555555, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 3'b001, 32'h05, 32'h0, TRAP ? 32'h0 : 32'h00005555, TRAP};

    reset_n = 1'b0; addr = '0; wdata = '0; mem_write = 1'b0; mem_read = 1'b0; funct3 = '0;
    cpu_enable = 1'b1; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    #12;
    check("reset_busy", busy, 1'b1);
    check("reset_dbg_ack", dbg_ack, 1'b0);
    check("reset_dbg_frame", dbg_frame, '0);

    // Store and load attempted throughout the clear must have no effect.
    mem_write = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0; wdata = 32'hDEADBEEF;
    @(negedge clk) reset_n = 1'b1;
    begin
      int cnt;
      cnt = 0;
      while (busy && cnt < 100) begin
        @(posedge clk); #1;
        cnt++;
        if (cnt == 3) check("rd_during_clear", rdata, 32'h0);
        if (cnt == 10) mem_write = 1'b0;
      end
      check("clear_cycles", cnt, DEPTH);
    end
    #2 check("rd_after_clear", rdata, 32'h0);
    check("word0_after_clear", word0, 32'h0);
    mem_read = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      mem_write = vecs[i].we; mem_read = vecs[i].re; funct3 = vecs[i].f3;
      addr = vecs[i].addr; wdata = vecs[i].wdata;
      #3;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_misaligned", i), misaligned, vecs[i].exp_mis);
    end
    @(posedge clk); #1;
    mem_write = 1'b0; mem_read = 1'b0;

    cpu_enable = 1'b0;
    dbg_txn(1'b1, 9'd9, 32'hCAFEF00D, "dbg_wr9");
    cpu_load(3'b010, 32'h24, 32'hCAFEF00D, "ld_after_dbg_wr");
    dbg_txn(1'b0, 9'd9, 32'h0, "dbg_rd9");
    check("frame_rd9", dbg_frame, {1'b0, 9'd9, 32'hCAFEF00D});
    dbg_txn(1'b0, 9'h019, 32'h0, "dbg_rd_wrap");
    check("frame_rd_wrap", dbg_frame, {1'b0, 9'h019, 32'hCAFEF00D});
    dbg_txn(1'b1, 9'd10, 32'h01020304, "dbg_wr10");
    check("frame_held", dbg_frame, {1'b0, 9'h019, 32'hCAFEF00D});

    // Core running: request must be ignored.
    cpu_enable = 1'b1;
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'd3;
    base = ack_cnt;
    repeat (6) @(posedge clk);
    #1 check("no_ack_cpu_enabled", ack_cnt - base, 0);
    check("frame_cpu_enabled", dbg_frame, {1'b0, 9'h019, 32'hCAFEF00D});

    // Core halts while a store is in flight: store lands, debug waits, then completes.
    mem_write = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h28; wdata = 32'h12345678;
    dbg_we = 1'b1; dbg_addr = 9'd10; dbg_wdata = 32'hAAAA5555; cpu_enable = 1'b0;
    base = ack_cnt;
    @(posedge clk); #1;
    check("store_first_rdata", rdata, 32'h12345678);
    check("store_first_no_ack", dbg_ack, 1'b0);
    @(posedge clk); #1;
    check("store_held_no_ack", dbg_ack, 1'b0);
    mem_write = 1'b0;
    lat = 0;
    while (!dbg_ack && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("pending_dbg_latency", lat, 1);
    check("pending_dbg_wrote", rdata, 32'hAAAA5555);
    dbg_req = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    check("pending_dbg_pulses", ack_cnt - base, 1);

    dbg_txn(1'b1, 9'd0, 32'h0BADC0DE, "dbg_wr0");
    check("word0_dbg", word0, 32'h0BADC0DE);

    // Dirty a few words, then abort a clear part-way and verify a full restart.
    cpu_store(3'b010, 32'h3C, 32'hFFFFFFFF);
    cpu_store(3'b010, 32'h08, 32'h87654321);
    cpu_load(3'b010, 32'h3C, 32'hFFFFFFFF, "ld_idx15_dirty");
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    repeat (7) @(posedge clk);
    #1 check("busy_mid_clear", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1 check("busy_in_abort", busy, 1'b1);
    check("frame_after_abort", dbg_frame, '0);
    @(negedge clk) reset_n = 1'b1;
    count_clear("restart_clear_cycles");
    check("word0_after_restart", word0, 32'h0);
    cpu_load(3'b010, 32'h3C, 32'h0, "ld_idx15_restart");
    cpu_load(3'b010, 32'h08, 32'h0, "ld_idx2_restart");
    cpu_load(3'b010, 32'h24, 32'h0, "ld_idx9_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
